// File: rtl/ifu_fetch_responder_pkg.sv
// Shared types and constants for the IFU fetch responder.
// The beat/line sizes fix the two-beat split of each fetch line.
package ifu_fetch_responder_pkg;

  localparam int unsigned FETCH_BEAT_BYTES  = 8;
  localparam int unsigned FETCH_LINE_BYTES  = 16;
  localparam int unsigned FETCH_LINE_OFF_W  = $clog2(FETCH_LINE_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StReq0,
    StRsp0,
    StReq1,
    StRsp1,
    StDone,
    StDrain
  } fetch_state_e;

endpackage

// File: rtl/ifu_line_buf.sv
// One-entry fetch-line bypass tag store, used when FETCH_RESP_BYPASS_EN is defined.
module ifu_line_buf
  import ifu_fetch_responder_pkg::*;
#(
  parameter int unsigned TagW = 64 - FETCH_LINE_OFF_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            fill_i,
  input  logic            clear_i,
  input  logic [TagW-1:0] fill_tag_i,
  input  logic [TagW-1:0] lookup_tag_i,
  output logic            hit_o
);

  logic            valid_q, valid_d;
  logic [TagW-1:0] tag_q, tag_d;

  // Only the tag is kept: while valid, pc_read_inst still holds the buffered line.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (fill_i) begin
      valid_d = 1'b1;
      tag_d   = fill_tag_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  assign hit_o = valid_q & (tag_q == lookup_tag_i);

endmodule

// File: rtl/ifu_fetch_responder.sv
// Fetches a 16-byte line as two 8-byte memory beats, with redirect/flush handling.
// Optional one-entry line bypass enabled by defining FETCH_RESP_BYPASS_EN.
module ifu_fetch_responder
  import ifu_fetch_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LINE_W = 128
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pc_index_valid,
  input  logic [ADDR_W-1:0] pc_index,
  output logic              pc_index_ready,
  output logic              pc_operation_done,
  output logic [LINE_W-1:0] pc_read_inst,
  input  logic              redirect_valid,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [63:0]       mem_rsp_data
);

  localparam int unsigned BeatW = FETCH_BEAT_BYTES * 8;
  localparam int unsigned TagW  = ADDR_W - FETCH_LINE_OFF_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [TagW-1:0]   req_tag;
  logic              accept;
  logic              buf_hit;
  logic              buf_fill;
  logic              abort;
  logic              unused_pc_off;

  assign req_tag        = pc_index[ADDR_W-1:FETCH_LINE_OFF_W];
  assign unused_pc_off  = ^pc_index[FETCH_LINE_OFF_W-1:0];
  assign pc_index_ready = (state_q == StIdle) & ~redirect_valid;
  assign accept         = pc_index_valid & pc_index_ready;
  assign pc_read_inst   = line_q;

  always_comb begin
    state_d           = state_q;
    base_d            = base_q;
    line_d            = line_q;
    mem_req_valid     = 1'b0;
    mem_req_addr      = base_q;
    pc_operation_done = 1'b0;
    abort             = 1'b0;
    buf_fill          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          base_d  = {req_tag, {FETCH_LINE_OFF_W{1'b0}}};
          state_d = buf_hit ? StDone : StReq0;
        end
      end
      StReq0, StReq1: begin
        if (state_q == StReq1) begin
          mem_req_addr = base_q + ADDR_W'(FETCH_BEAT_BYTES);
        end
        if (redirect_valid) begin
          abort   = 1'b1;
          state_d = StIdle;
        end else begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            state_d = (state_q == StReq0) ? StRsp0 : StRsp1;
          end
        end
      end
      StRsp0, StRsp1: begin
        if (redirect_valid) begin
          // A beat arriving with the redirect is the one outstanding response: drop it.
          abort   = 1'b1;
          state_d = mem_rsp_valid ? StIdle : StDrain;
        end else if (mem_rsp_valid) begin
          if (state_q == StRsp0) begin
            line_d[BeatW-1:0] = mem_rsp_data;
            state_d           = StReq1;
          end else begin
            line_d[LINE_W-1:BeatW] = mem_rsp_data;
            state_d                = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (redirect_valid) begin
          abort = 1'b1;
        end else begin
          pc_operation_done = 1'b1;
          buf_fill          = 1'b1;
        end
      end
      StDrain: begin
        if (mem_rsp_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      base_q  <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      line_q  <= line_d;
    end
  end

`ifdef FETCH_RESP_BYPASS_EN
  ifu_line_buf #(
    .TagW(TagW)
  ) u_line_buf (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .fill_i      (buf_fill),
    .clear_i     (abort),
    .fill_tag_i  (base_q[ADDR_W-1:FETCH_LINE_OFF_W]),
    .lookup_tag_i(req_tag),
    .hit_o       (buf_hit)
  );
`else
  logic unused_buf_ctl;
  assign buf_hit        = 1'b0;
  assign unused_buf_ctl = buf_fill ^ abort;
`endif

endmodule

// File: tb/tb_ifu_fetch_responder.sv
// Directed scoreboard bench for ifu_fetch_responder with a bench-side memory model.
module tb_ifu_fetch_responder;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         pc_index_valid;
  logic [63:0]  pc_index;
  logic         pc_index_ready;
  logic         pc_operation_done;
  logic [127:0] pc_read_inst;
  logic         redirect_valid;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [63:0]  mem_req_addr;
  logic         mem_rsp_valid;
  logic [63:0]  mem_rsp_data;

  ifu_fetch_responder #(
    .ADDR_W(64),
    .LINE_W(128)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .pc_index_valid   (pc_index_valid),
    .pc_index         (pc_index),
    .pc_index_ready   (pc_index_ready),
    .pc_operation_done(pc_operation_done),
    .pc_read_inst     (pc_read_inst),
    .redirect_valid   (redirect_valid),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_addr     (mem_req_addr),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_cyc, done_cyc, first_req_cyc, done_cnt, stall_cnt, extra_delay;
  logic         hold_chk;
  logic [63:0]  hold_addr;
  logic [127:0] exp_q[$];
  logic [63:0]  req_log[$];
  int           pend_due[$];
  logic [63:0]  pend_addr[$];

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
  endfunction

  function automatic logic [127:0] line_of(input logic [63:0] base);
    return {mem_word(base + 64'd8), mem_word(base)};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present memory response, observe outputs, advance past the edge.
  task automatic cyc_step();
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(pend_addr[0]);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
    mem_req_ready = (stall_cnt == 0);
    #1;
    if (hold_chk && !redirect_valid) begin
      check("req_hold_valid", 128'(mem_req_valid), 128'(1'b1));
      check("req_hold_addr", 128'(mem_req_addr), 128'(hold_addr));
    end
    hold_chk  = mem_req_valid & ~mem_req_ready;
    hold_addr = mem_req_addr;
    if (mem_req_valid && mem_req_ready) begin
      pend_due.push_back(cyc + 1 + extra_delay);
      pend_addr.push_back(mem_req_addr);
      req_log.push_back(mem_req_addr);
      if (first_req_cyc < 0) first_req_cyc = cyc;
    end
    if (pc_index_valid && pc_index_ready) acc_cyc = cyc;
    if (pc_operation_done) begin
      done_cyc = cyc;
      done_cnt++;
      if (exp_q.size() == 0) check("unexpected_done", 128'(pc_operation_done), 128'(1'b0));
      else check("line_data", pc_read_inst, exp_q.pop_front());
    end
    if (mem_rsp_valid) begin
      void'(pend_due.pop_front());
      void'(pend_addr.pop_front());
    end
    @(posedge clock);
    cyc++;
    if (stall_cnt > 0) stall_cnt--;
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget && done_cnt == start; i++) cyc_step();
    if (done_cnt == start) check({tag, "_timeout"}, 128'(done_cnt), 128'(start + 1));
  endtask

  task automatic issue(input logic [63:0] pc);
    pc_index       = pc;
    pc_index_valid = 1'b1;
    acc_cyc        = -100;
    first_req_cyc  = -1;
    cyc_step();
    pc_index_valid = 1'b0;
  endtask

  int n0, d0, t0;

  initial begin
    reset_n = 1'b0; pc_index_valid = 1'b0; pc_index = '0; redirect_valid = 1'b0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    done_cnt = 0; stall_cnt = 0; extra_delay = 0; hold_chk = 1'b0; hold_addr = '0;
    acc_cyc = -100; done_cyc = -100; first_req_cyc = -1;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    check("rst_ready", 128'(pc_index_ready), 128'(1'b1));
    check("rst_req_valid", 128'(mem_req_valid), 128'(1'b0));
    check("rst_done", 128'(pc_operation_done), 128'(1'b0));
    check("rst_line", pc_read_inst, 128'(0));

    // Zero-wait miss: unaligned PC, two beats, done at T+5.
    n0 = req_log.size();
    exp_q.push_back(line_of(64'h8000_0000));
    issue(64'h8000_0004);
    wait_done("t1", 20);
    check("t1_req_cnt", 128'(req_log.size() - n0), 128'(2));
    check("t1_addr0", 128'(req_log[n0]), 128'(64'h8000_0000));
    check("t1_addr1", 128'(req_log[n0+1]), 128'(64'h8000_0008));
    check("t1_first_req", 128'(first_req_cyc - acc_cyc), 128'(1));
    check("t1_latency", 128'(done_cyc - acc_cyc), 128'(5));

    // Three stall cycles in REQ0: request must hold (checked per cycle in cyc_step).
    n0 = req_log.size();
    exp_q.push_back(line_of(64'h2000_0010));
    issue(64'h2000_001C);
    stall_cnt = 3;
    wait_done("t2", 30);
    check("t2_req_cnt", 128'(req_log.size() - n0), 128'(2));
    check("t2_latency", 128'(done_cyc - acc_cyc), 128'(8));

    // Redirect in RSP0, response 4 cycles late: drain, no done.
    d0 = done_cnt;
    extra_delay = 4;
    issue(64'h3000_0020);
    t0 = acc_cyc;
    cyc_step();
    extra_delay = 0;
    redirect_valid = 1'b1;
    cyc_step();
    redirect_valid = 1'b0;
    while (cyc < t0 + 6) cyc_step();
    check("t3_drain_ready", 128'(pc_index_ready), 128'(1'b0));
    cyc_step();
    check("t3_ready_back", 128'(pc_index_ready), 128'(1'b1));
    check("t3_no_done", 128'(done_cnt), 128'(d0));
    exp_q.push_back(line_of(64'h3000_0040));
    issue(64'h3000_0048);
    wait_done("t3b", 20);
    check("t3b_latency", 128'(done_cyc - acc_cyc), 128'(5));

    // Redirect in DONE: pulse suppressed, IDLE next cycle, line kept.
    d0 = done_cnt;
    issue(64'h4000_0000);
    repeat (4) cyc_step();
    redirect_valid = 1'b1;
    #1;
    check("t4_done_suppressed", 128'(pc_operation_done), 128'(1'b0));
    cyc_step();
    redirect_valid = 1'b0;
    #1;
    check("t4_idle_ready", 128'(pc_index_ready), 128'(1'b1));
    check("t4_line_kept", pc_read_inst, line_of(64'h4000_0000));
    check("t4_no_done", 128'(done_cnt), 128'(d0));

    // Same line twice: bypass hit when enabled, otherwise a normal miss.
    exp_q.push_back(line_of(64'h0000_1000));
    issue(64'h0000_1000);
    wait_done("t5a", 20);
    n0 = req_log.size();
    exp_q.push_back(line_of(64'h0000_1000));
    issue(64'h0000_100C);
    wait_done("t5b", 20);
`ifdef FETCH_RESP_BYPASS_EN
    check("t5_hit_latency", 128'(done_cyc - acc_cyc), 128'(1));
    check("t5_hit_no_req", 128'(req_log.size() - n0), 128'(0));
`else
    check("t5_miss_latency", 128'(done_cyc - acc_cyc), 128'(5));
    check("t5_miss_req_cnt", 128'(req_log.size() - n0), 128'(2));
`endif

    // Asynchronous reset in RSP1, then a stray response after release.
    d0 = done_cnt;
    issue(64'h5000_0000);
    cyc_step();
    cyc_step();
    extra_delay = 6;
    cyc_step();
    extra_delay = 0;
    #1 reset_n = 1'b0;
    #1;
    check("t6_rst_done", 128'(pc_operation_done), 128'(1'b0));
    check("t6_rst_req_valid", 128'(mem_req_valid), 128'(1'b0));
    check("t6_rst_line", pc_read_inst, 128'(0));
    check("t6_rst_ready", 128'(pc_index_ready), 128'(1'b1));
    hold_chk = 1'b0;
    cyc_step();
    reset_n = 1'b1;
    repeat (10) cyc_step();
    check("t6_stray_consumed", 128'(pend_due.size()), 128'(0));
    check("t6_no_done", 128'(done_cnt), 128'(d0));
    check("t6_ready", 128'(pc_index_ready), 128'(1'b1));

    exp_q.push_back(line_of(64'h6000_0000));
    issue(64'h6000_0008);
    wait_done("t7", 20);
    check("t7_latency", 128'(done_cyc - acc_cyc), 128'(5));
    check("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_responder.md
IFU_FETCH_RESPONDER -- requirements
Module: ifu_fetch_responder

Interface
REQ-001 Parameter: ADDR_W, 64, fetch/memory address width.
REQ-002 Parameter: LINE_W, 128, returned fetch-line width (two 64-bit memory beats).
REQ-003 clock  in  1  single clock; all state on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 pc_index_valid  in  1  fetch request valid from IFU.
REQ-006 pc_index  in  ADDR_W  fetch PC; low 4 bits ignored.
REQ-007 pc_index_ready  out  1  responder can accept a request this cycle.
REQ-008 pc_operation_done  out  1  one-cycle pulse: pc_read_inst valid.
REQ-009 pc_read_inst  out  LINE_W  16-byte-aligned fetch line.
REQ-010 redirect_valid  in  1  flush: abort the in-flight fetch.
REQ-011 mem_req_valid / mem_req_ready  out / in  1 / 1  memory read request handshake.
REQ-012 mem_req_addr  out  ADDR_W  8-byte-aligned beat address.
REQ-013 mem_rsp_valid / mem_rsp_data  in / in  1 / 64  memory read data, one beat per request, in order.

Function
REQ-014 FSM states: IDLE, REQ0, RSP0, REQ1, RSP1, DONE, DRAIN.
REQ-015 pc_index_ready = 1 only in IDLE with redirect_valid = 0.
REQ-016 Accept on pc_index_valid & pc_index_ready: latch base = {pc_index[ADDR_W-1:4], 4'b0}; IDLE->REQ0.
REQ-017 REQ0: mem_req_valid = 1, mem_req_addr = base; on mem_req_ready -> RSP0.
REQ-018 RSP0: on mem_rsp_valid capture pc_read_inst[63:0] = mem_rsp_data -> REQ1.
REQ-019 REQ1: mem_req_valid = 1, mem_req_addr = base + 8; on mem_req_ready -> RSP1.
REQ-020 RSP1: on mem_rsp_valid capture pc_read_inst[127:64] -> DONE.
REQ-021 DONE: pc_operation_done = 1 for exactly one cycle; -> IDLE next cycle.
REQ-022 Minimum miss latency: accept at cycle T, first mem_req_valid at T+1, done at T+5 with zero-wait memory.
REQ-023 pc_read_inst holds its value from DONE until the next capture; it is not cleared by redirect.
REQ-024 mem_req_valid, once raised, stays high with a stable address until mem_req_ready, unless a redirect aborts.
REQ-025 Redirect in REQ0/REQ1: drop mem_req_valid that cycle; -> IDLE; no done.
REQ-026 Redirect in RSP0/RSP1: -> DRAIN; DRAIN waits for the single outstanding mem_rsp_valid, discards it, -> IDLE; no done.
REQ-027 Redirect in DONE: suppress pc_operation_done that cycle; -> IDLE.
REQ-028 Redirect coincident with mem_rsp_valid in RSP0/RSP1: the beat is discarded; -> IDLE directly.
REQ-029 Redirect in DRAIN or IDLE: no effect beyond REQ-015.
REQ-030 mem_rsp_valid outside RSP0/RSP1/DRAIN is ignored.

Reset
REQ-031 Reset: state = IDLE; pc_operation_done = 0; mem_req_valid = 0; pc_read_inst = 0; base = 0; pc_index_ready = 1 after reset release.
REQ-032 Reset mid-fetch abandons all state; any later stray mem_rsp_valid is ignored per REQ-030.

Configuration
REQ-033 Macro FETCH_RESP_BYPASS_EN: when defined, a one-entry line buffer (tag = base[ADDR_W-1:4], valid bit) is filled at every completed DONE.
REQ-034 With FETCH_RESP_BYPASS_EN defined, an accepted request whose base tag matches a valid entry goes IDLE->DONE with no memory traffic; done arrives at T+1; redirect rules of REQ-027 apply.
REQ-035 With FETCH_RESP_BYPASS_EN defined, the buffer valid bit clears on reset and on any aborted fetch.
REQ-036 Without FETCH_RESP_BYPASS_EN, no line buffer exists and every request takes the REQ0..RSP1 path.

Structure
REQ-037 Shared package holds the FSM state enum, FETCH_BEAT_BYTES = 8, and FETCH_LINE_BYTES = 16.
REQ-038 One sub-module, ifu_line_buf, implements the bypass entry and is instantiated only under FETCH_RESP_BYPASS_EN.

Verification
REQ-039 Zero-wait memory, request pc_index = 0x8000_0004 -> mem addresses 0x8000_0000 then 0x8000_0008; done at T+5; pc_read_inst = {beat1, beat0}.
REQ-040 mem_req_ready low 3 cycles in REQ0 -> mem_req_valid and address stable all 3 cycles; exactly two requests issued.
REQ-041 Redirect in RSP0, response arriving 4 cycles later -> no done; pc_index_ready returns the cycle after the response; the next fetch returns correct data.
REQ-042 Redirect in DONE -> pc_operation_done stays 0; the state is IDLE next cycle.
REQ-043 With FETCH_RESP_BYPASS_EN defined, two consecutive fetches 0x1000 then 0x100C -> the second produces done at T+1 with no mem_req_valid and the same pc_read_inst.
REQ-044 reset_n asserted asynchronously in RSP1 -> all outputs go to reset values immediately; a stray response after release produces no done.
